div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/div_sched.sv
// div_sched: sequences a multi-cycle divider on behalf of the EX stage.
//
// Accepts a divide request from EX, latches the operands and holds a start level
// to the divider. It collects the {remainder, quotient} result and presents it to
// EX until EX is no longer stalled. Flushes and timeouts abort the divider with a
// one-cycle annul pulse.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   req_i           - EX holds a divide instruction
//   signed_i        - 1 = signed divide
//   opdata1_i/2_i   - dividend / divisor
//   annul_i         - pipeline flush, discard the current divide
//   hold_i          - EX stalled by a later stage, keep the result
//   div_result_i    - divider result {remainder, quotient}
//   div_ready_i     - divider result valid
//   div_start_o     - start level to the divider, held while busy
//   div_annul_o     - one-cycle abort pulse to the divider
//   div_signed_o    - latched signed_i
//   div_opdata1_o/2 - latched operands
//   result_o        - {hi = remainder, lo = quotient}
//   result_valid_o  - result_o valid
//   stall_req_o     - stall request (combinational)
//   dz_o            - last completed divide had a zero divisor
//   timeout_o       - last completed divide ran out of cycle budget
module div_sched #(
    parameter int unsigned MAX_CYCLES = 40,
    parameter bit          DZ_FAST    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    input  logic        hold_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic [63:0] result_o,
    output logic        result_valid_o,
    output logic        stall_req_o,
    output logic        dz_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    localparam logic [7:0] CntLast = 8'(MAX_CYCLES - 1);

    state_t     state_q;
    logic [7:0] cnt_q;

    // Stall is the only combinational output: it must rise in the accept cycle.
    always_comb begin
        stall_req_o = 1'b0;
        unique case (state_q)
            StIdle:  stall_req_o = req_i & ~annul_i;
            StBusy:  stall_req_o = 1'b1;
            default: stall_req_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= 8'd0;
            div_start_o    <= 1'b0;
            div_annul_o    <= 1'b0;
            div_signed_o   <= 1'b0;
            div_opdata1_o  <= 32'd0;
            div_opdata2_o  <= 32'd0;
            result_o       <= 64'd0;
            result_valid_o <= 1'b0;
            dz_o           <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            div_annul_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i && !annul_i) begin
                        div_signed_o  <= signed_i;
                        div_opdata1_o <= opdata1_i;
                        div_opdata2_o <= opdata2_i;
                        timeout_o     <= 1'b0;
                        if (DZ_FAST && opdata2_i == 32'd0) begin
                            // Zero divisor short-cut: never wake the divider.
                            state_q        <= StDone;
                            result_o       <= 64'd0;
                            result_valid_o <= 1'b1;
                            dz_o           <= 1'b1;
                        end else begin
                            state_q     <= StBusy;
                            cnt_q       <= 8'd0;
                            dz_o        <= 1'b0;
                            div_start_o <= 1'b1;
                        end
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q + 8'd1;
                    // Flush wins over a coincident ready; the result is dropped.
                    if (annul_i || !req_i) begin
                        state_q     <= StIdle;
                        div_start_o <= 1'b0;
                        div_annul_o <= 1'b1;
                    end else if (div_ready_i) begin
                        state_q        <= StDone;
                        div_start_o    <= 1'b0;
                        result_o       <= div_result_i;
                        result_valid_o <= 1'b1;
                    end else if (cnt_q == CntLast) begin
                        state_q        <= StDone;
                        div_start_o    <= 1'b0;
                        div_annul_o    <= 1'b1;
                        result_o       <= 64'd0;
                        result_valid_o <= 1'b1;
                        timeout_o      <= 1'b1;
                    end
                end
                StDone: begin
                    // No new request is taken here; it waits for the next IDLE cycle.
                    if (!hold_i || annul_i) begin
                        state_q        <= StIdle;
                        result_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    div_start_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
